sd_sector_writer: RTL and testbench
===================================

Name: sd_sector_writer

Overview:
AXI-Lite write master sitting directly upstream of sd_card_reader's AXI-Lite slave port. It accepts a sector-write command (start sector, sector count) and a 32-bit word stream. It converts each word into a single AXI-Lite write at byte address sector*512 + word*4. It also tracks write responses and signals completion, replacing hand-coded write FSMs in top-level designs.

Parameters:
WORDS_PER_SECTOR, 128, 32-bit words per 512-byte sector; must be a power of two.
CNT_W, 16, width of the sector-count field.

Ports:
aclk  in  1  system clock
aresetn  in  1  reset; synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_sector  in  32  first sector index
cmd_count  in  CNT_W  number of sectors to write
s_tdata  in  32  write word stream
s_tvalid  in  1  stream valid
s_tready  out  1  stream ready
m_axil_awaddr  out  32  write address
m_axil_awprot  out  3  constant 3'b000
m_axil_awvalid  out  1  address valid
m_axil_awready  in  1  address ready
m_axil_wdata  out  32  write data
m_axil_wstrb  out  4  constant 4'b1111
m_axil_wvalid  out  1  data valid
m_axil_wready  in  1  data ready
m_axil_bresp  in  2  write response
m_axil_bvalid  in  1  response valid
m_axil_bready  out  1  response ready
busy  out  1  high whenever not IDLE
done  out  1  one-cycle pulse at command completion
err  out  1  sticky: at least one non-OKAY bresp in the current command

Behaviour:
- Reset: on the first aclk edge with aresetn=0, go to IDLE. Registered outputs clear as follows: awvalid, wvalid, bready, s_tready, done, err and busy are 0. cmd_ready is 1. awaddr and wdata are 0.
- Reset mid-transfer abandons the transfer immediately. No valid remains asserted after that edge.
- IDLE: cmd_ready=1. When cmd_valid is high, latch sector=cmd_sector, remaining=cmd_count and word_idx=0, and clear err.
  - If cmd_count==0: pulse done on the next cycle, issue no writes, return to IDLE.
  - Otherwise go to FETCH.
- FETCH: s_tready=1. On s_tvalid, capture wdata=s_tdata and awaddr=(sector<<9)+(word_idx<<2). The address is truncated to 32 bits, so it wraps modulo 2^32. Go to WRITE.
- WRITE: awvalid and wvalid rise together on entry. Each channel drops independently on the cycle after its own handshake. Either channel may be accepted first, or both in the same cycle. Leave for RESP once both handshakes have completed.
- RESP: bready=1. On bvalid:
  - If bresp!=2'b00, set err.
  - If word_idx==WORDS_PER_SECTOR-1: set word_idx=0, sector+=1 (wraps at 2^32), remaining-=1.
  - Otherwise word_idx+=1.
  - If remaining reaches 0: pulse done and go to IDLE. Otherwise return to FETCH.
- Only one write is ever outstanding. Minimum cost is 3 cycles per word (FETCH, WRITE, RESP) when the slave and stream are always ready.
- bvalid arriving outside RESP is ignored; bready is 0 there.
- cmd_valid during busy is not accepted (cmd_ready=0).
- done and cmd_ready never assert in the same cycle. IDLE is re-entered the cycle after the done pulse.

Optional Feature:
Macro: SD_WR_ABORT_ON_ERR_EN.
- Defined: a non-OKAY bresp sets err, pulses done on the next cycle and returns to IDLE. Remaining words are not consumed from the stream.
- Undefined: err is recorded and the transfer continues to completion.

Decomposition:
- Package sd_pkg holds:
  - enum sd_wr_state_t {IDLE, FETCH, WRITE, RESP}
  - localparam SD_SECTOR_BYTES=512
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10
- No sub-module is warranted; single flat FSM module.

Test Plan:
- cmd_sector=0, count=1, stream 32'hFFFFA000+i, slave always ready:
  - 128 writes, addresses 0x000..0x1FC in order, data matches.
  - done pulses once, 384 cycles after first FETCH.
- cmd_sector=5, count=2:
  - first address 0xA00; word 128 at address 0xC00; last address 0xDFC.
  - done pulses once; err=0.
- Slave asserts awready 3 cycles before wready (and the reverse):
  - awvalid drops after its own handshake while wvalid stays high.
  - exactly one write per word, no duplicate.
- bresp=SLVERR on word 10, count=1:
  - err=1 and 128 writes total (macro undefined).
  - with SD_WR_ABORT_ON_ERR_EN: 11 writes, done pulse, then IDLE.
- cmd_count=0 → no AXI activity; done pulses exactly once, one cycle after accept.
- aresetn low for 1 cycle while in WRITE with awvalid=1:
  - next cycle all valids are 0 and cmd_ready=1.
  - a new command executes correctly from word 0.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD sector writer.
// Contents: write FSM state enum, sector geometry, AXI response codes.
package sd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WRITE = 2'd2,
      RESP  = 2'd3
   } sd_wr_state_t;

   localparam int unsigned SD_SECTOR_BYTES = 512;
   localparam int unsigned SD_SECTOR_SHIFT = $clog2(SD_SECTOR_BYTES);

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage

// File: rtl/sd_sector_writer.sv
// sd_sector_writer: AXI-Lite write master that turns a sector-write command
// plus a 32-bit word stream into one AXI-Lite write per word at byte address
// sector*512 + word*4, one write outstanding at a time.
//
// Ports:
//   aclk, aresetn           clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake (ready only in IDLE)
//   cmd_sector, cmd_count   first sector index, number of sectors
//   s_tdata/s_tvalid/s_tready   write word stream
//   m_axil_aw*, m_axil_w*, m_axil_b*   AXI-Lite write master channels
//   busy, done, err         status: active, completion pulse, sticky error
//
// Build option: SD_WR_ABORT_ON_ERR_EN - when defined, a non-OKAY write
// response ends the command immediately (done pulse, back to IDLE).
module sd_sector_writer
   import sd_pkg::*;
#(
   parameter int unsigned WORDS_PER_SECTOR = 128,
   parameter int unsigned CNT_W            = 16
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_sector,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic [31:0]      s_tdata,
   input  logic             s_tvalid,
   output logic             s_tready,
   output logic [31:0]      m_axil_awaddr,
   output logic [2:0]       m_axil_awprot,
   output logic             m_axil_awvalid,
   input  logic             m_axil_awready,
   output logic [31:0]      m_axil_wdata,
   output logic [3:0]       m_axil_wstrb,
   output logic             m_axil_wvalid,
   input  logic             m_axil_wready,
   input  logic [1:0]       m_axil_bresp,
   input  logic             m_axil_bvalid,
   output logic             m_axil_bready,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int unsigned IDX_W = (WORDS_PER_SECTOR > 1) ? $clog2(WORDS_PER_SECTOR) : 1;

   sd_wr_state_t     state;
   logic [31:0]      sector;
   logic [CNT_W-1:0] remaining;
   logic [IDX_W-1:0] word_idx;

   logic [31:0] sector_base;
   logic [31:0] word_off;
   logic        last_word;
   logic        last_sector;
   logic        resp_bad;

   // Full-word writes, unprivileged secure data access.
   assign m_axil_awprot = 3'b000;
   assign m_axil_wstrb  = 4'b1111;

   // Byte address pieces; the sum wraps modulo 2^32.
   assign sector_base = sector << SD_SECTOR_SHIFT;
   assign word_off    = 32'(word_idx) << 2;
   assign last_word   = (word_idx == IDX_W'(WORDS_PER_SECTOR - 1));
   assign last_sector = (remaining == CNT_W'(1));
   assign resp_bad    = (m_axil_bresp != AXI_RESP_OKAY);

   // Command FSM with registered outputs.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state          <= IDLE;
         sector         <= '0;
         remaining      <= '0;
         word_idx       <= '0;
         cmd_ready      <= 1'b1;
         s_tready       <= 1'b0;
         m_axil_awaddr  <= '0;
         m_axil_awvalid <= 1'b0;
         m_axil_wdata   <= '0;
         m_axil_wvalid  <= 1'b0;
         m_axil_bready  <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         err            <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               // cmd_ready low in IDLE only during the done pulse cycle.
               if (!cmd_ready) begin
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
               end else if (cmd_valid) begin
                  sector    <= cmd_sector;
                  remaining <= cmd_count;
                  word_idx  <= '0;
                  err       <= 1'b0;
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  if (cmd_count == '0) begin
                     done <= 1'b1;
                  end else begin
                     state    <= FETCH;
                     s_tready <= 1'b1;
                  end
               end
            end

            FETCH: begin
               if (s_tvalid) begin
                  s_tready       <= 1'b0;
                  m_axil_wdata   <= s_tdata;
                  m_axil_awaddr  <= sector_base + word_off;
                  m_axil_awvalid <= 1'b1;
                  m_axil_wvalid  <= 1'b1;
                  state          <= WRITE;
               end
            end

            WRITE: begin
               // Each channel retires on its own handshake.
               if (m_axil_awready) m_axil_awvalid <= 1'b0;
               if (m_axil_wready)  m_axil_wvalid  <= 1'b0;
               if ((!m_axil_awvalid || m_axil_awready) &&
                   (!m_axil_wvalid  || m_axil_wready)) begin
                  state         <= RESP;
                  m_axil_bready <= 1'b1;
               end
            end

            RESP: begin
               if (m_axil_bvalid) begin
                  m_axil_bready <= 1'b0;
                  if (resp_bad) err <= 1'b1;
                  if (last_word) begin
                     word_idx  <= '0;
                     sector    <= sector + 32'd1;
                     remaining <= remaining - CNT_W'(1);
                  end else begin
                     word_idx <= word_idx + IDX_W'(1);
                  end
`ifdef SD_WR_ABORT_ON_ERR_EN
                  if (resp_bad || (last_word && last_sector)) begin
`else
                  if (last_word && last_sector) begin
`endif
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     s_tready <= 1'b1;
                     state    <= FETCH;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_sector_writer.sv
// Directed testbench for sd_sector_writer with a small AXI-Lite slave model
// (configurable awready/wready latency, injectable SLVERR) and a counting
// word-stream source.
module tb_sd_sector_writer;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [31:0] cmd_sector;
   logic [15:0] cmd_count;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [31:0] m_axil_awaddr;
   logic [2:0]  m_axil_awprot;
   logic        m_axil_awvalid;
   logic        m_axil_awready;
   logic [31:0] m_axil_wdata;
   logic [3:0]  m_axil_wstrb;
   logic        m_axil_wvalid;
   logic        m_axil_wready;
   logic [1:0]  m_axil_bresp;
   logic        m_axil_bvalid;
   logic        m_axil_bready;
   logic        busy;
   logic        done;
   logic        err;

   int tests_run    = 0;
   int tests_failed = 0;

   sd_sector_writer #(.WORDS_PER_SECTOR(128), .CNT_W(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sector(cmd_sector), .cmd_count(cmd_count),
      .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
      .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
      .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
      .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
      .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
      .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid),
      .m_axil_bready(m_axil_bready),
      .busy(busy), .done(done), .err(err)
   );

   always #5 aclk = ~aclk;

   // ---------------- stream source: word n carries stream_base + n
   localparam logic [31:0] STREAM_BASE = 32'hFFFFA000;
   int stream_idx = 0;
   assign s_tvalid = 1'b1;
   assign s_tdata  = STREAM_BASE + 32'(stream_idx);
   always @(posedge aclk) if (s_tvalid && s_tready) stream_idx <= stream_idx + 1;

   // ---------------- AXI-Lite slave model
   int aw_delay = 0;
   int w_delay  = 0;
   int err_at   = -1;
   int aw_cnt   = 0;
   int w_cnt    = 0;
   logic aw_got = 1'b0, w_got = 1'b0;
   logic [31:0] cur_addr, cur_data;
   logic [31:0] addr_q[$];
   logic [31:0] data_q[$];
   int dup_cnt = 0;
   int aw_first_cyc = 0;
   int w_first_cyc  = 0;
   logic aw_hs, w_hs;
   logic [31:0] a_now, d_now;

   assign m_axil_awready = (aw_cnt >= aw_delay);
   assign m_axil_wready  = (w_cnt >= w_delay);

   always @(posedge aclk) begin
      if (!aresetn) begin
         aw_got        <= 1'b0;
         w_got         <= 1'b0;
         aw_cnt        <= 0;
         w_cnt         <= 0;
         m_axil_bvalid <= 1'b0;
         m_axil_bresp  <= 2'b00;
      end else begin
         aw_hs = m_axil_awvalid && m_axil_awready;
         w_hs  = m_axil_wvalid && m_axil_wready;
         if (aw_hs && aw_got) dup_cnt <= dup_cnt + 1;
         if (w_hs && w_got)   dup_cnt <= dup_cnt + 1;
         if (aw_got && !m_axil_awvalid && m_axil_wvalid) aw_first_cyc <= aw_first_cyc + 1;
         if (w_got && !m_axil_wvalid && m_axil_awvalid)  w_first_cyc  <= w_first_cyc + 1;
         aw_cnt <= (m_axil_awvalid && !m_axil_awready) ? aw_cnt + 1 : 0;
         w_cnt  <= (m_axil_wvalid && !m_axil_wready) ? w_cnt + 1 : 0;
         if (m_axil_bvalid && m_axil_bready) m_axil_bvalid <= 1'b0;
         a_now = aw_hs ? m_axil_awaddr : cur_addr;
         d_now = w_hs ? m_axil_wdata : cur_data;
         if ((aw_got || aw_hs) && (w_got || w_hs)) begin
            m_axil_bresp  <= (addr_q.size() == err_at) ? 2'b10 : 2'b00;
            m_axil_bvalid <= 1'b1;
            addr_q.push_back(a_now);
            data_q.push_back(d_now);
            aw_got <= 1'b0;
            w_got  <= 1'b0;
         end else begin
            if (aw_hs) begin aw_got <= 1'b1; cur_addr <= m_axil_awaddr; end
            if (w_hs)  begin w_got  <= 1'b1; cur_data <= m_axil_wdata;  end
         end
      end
   end

   // Issue one command from a negedge and follow it to completion.
   // kf: first cycle s_tready seen, kd: first done cycle (cycles counted from accept).
   task automatic run_cmd(input logic [31:0] sec, input logic [15:0] cnt, input int budget,
                          output int nwr, output int ndone, output int kf, output int kd,
                          output int q0, output int sidx0, output bit tmo);
      for (int i = 0; i < 10 && !cmd_ready; i++) @(negedge aclk);
      q0 = addr_q.size();
      sidx0 = stream_idx;
      cmd_sector = sec;
      cmd_count  = cnt;
      cmd_valid  = 1'b1;
      kf = -1; kd = -1; ndone = 0; tmo = 1'b1;
      for (int k = 1; k <= budget; k++) begin
         @(negedge aclk);
         cmd_valid = 1'b0;
         if (s_tready && kf < 0) kf = k;
         if (done) begin
            ndone++;
            if (kd < 0) kd = k;
         end
         if (kd >= 0 && k >= kd + 3) begin
            tmo = 1'b0;
            break;
         end
      end
      nwr = addr_q.size() - q0;
   endtask

   task automatic test_reset();
      tests_run++;
      if ({cmd_ready, busy, done, err} !== 4'b1000) begin
         tests_failed++;
         $display("FAIL reset_status got ready/busy/done/err=%b want 1000", {cmd_ready, busy, done, err});
      end
      tests_run++;
      if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, s_tready} !== 4'b0000) begin
         tests_failed++;
         $display("FAIL reset_valids got aw/w/b/s=%b want 0000",
                  {m_axil_awvalid, m_axil_wvalid, m_axil_bready, s_tready});
      end
      tests_run++;
      if (m_axil_awaddr !== 32'h0 || m_axil_wdata !== 32'h0 || m_axil_wstrb !== 4'hF || m_axil_awprot !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_regs got addr=%h data=%h strb=%h prot=%b want 0/0/f/000",
                  m_axil_awaddr, m_axil_wdata, m_axil_wstrb, m_axil_awprot);
      end
   endtask

   task automatic test_single_sector();
      int nwr, nd, kf, kd, q0, s0, bad;
      bit tmo;
      run_cmd(32'd0, 16'd1, 1000, nwr, nd, kf, kd, q0, s0, tmo);
      tests_run++;
      if (tmo !== 1'b0 || nwr !== 128) begin
         tests_failed++;
         $display("FAIL single_count got writes=%0d timeout=%0d want 128/0", nwr, tmo);
      end
      bad = 0;
      for (int i = 0; i < nwr; i++)
         if (addr_q[q0+i] !== 32'(i*4) || data_q[q0+i] !== 32'hFFFFA000 + 32'(i)) bad++;
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL single_addr_data got %0d bad words want 0", bad);
      end
      tests_run++;
      if (nd !== 1 || kd - kf !== 384) begin
         tests_failed++;
         $display("FAIL single_done got pulses=%0d latency=%0d want 1/384", nd, kd - kf);
      end
   endtask

   task automatic test_two_sectors();
      int nwr, nd, kf, kd, q0, s0, bad;
      bit tmo;
      run_cmd(32'd5, 16'd2, 2000, nwr, nd, kf, kd, q0, s0, tmo);
      tests_run++;
      if (tmo !== 1'b0 || nwr !== 256) begin
         tests_failed++;
         $display("FAIL two_count got writes=%0d timeout=%0d want 256/0", nwr, tmo);
      end
      if (nwr == 256) begin
         tests_run++;
         if (addr_q[q0] !== 32'hA00 || addr_q[q0+128] !== 32'hC00 || addr_q[q0+255] !== 32'hDFC) begin
            tests_failed++;
            $display("FAIL two_addr_marks got %h %h %h want a00 c00 dfc",
                     addr_q[q0], addr_q[q0+128], addr_q[q0+255]);
         end
      end
      bad = 0;
      for (int i = 0; i < nwr; i++)
         if (addr_q[q0+i] !== 32'hA00 + 32'(i*4) || data_q[q0+i] !== STREAM_BASE + 32'(s0 + i)) bad++;
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL two_addr_data got %0d bad words want 0", bad);
      end
      tests_run++;
      if (nd !== 1 || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL two_done got pulses=%0d err=%b want 1/0", nd, err);
      end
   endtask

   // Ready skew between channels; aw_first selects which side is accepted early.
   task automatic test_skew(input bit aw_first);
      int nwr, nd, kf, kd, q0, s0, bad, aw0, w0, dup0;
      bit tmo;
      aw_delay = aw_first ? 0 : 3;
      w_delay  = aw_first ? 3 : 0;
      aw0 = aw_first_cyc; w0 = w_first_cyc; dup0 = dup_cnt;
      run_cmd(32'd1, 16'd1, 3000, nwr, nd, kf, kd, q0, s0, tmo);
      aw_delay = 0; w_delay = 0;
      tests_run++;
      if (tmo !== 1'b0 || nwr !== 128 || dup_cnt - dup0 !== 0 || nd !== 1) begin
         tests_failed++;
         $display("FAIL skew%0d_count got writes=%0d dups=%0d done=%0d timeout=%0d want 128/0/1/0",
                  aw_first, nwr, dup_cnt - dup0, nd, tmo);
      end
      bad = 0;
      for (int i = 0; i < nwr; i++)
         if (addr_q[q0+i] !== 32'h200 + 32'(i*4) || data_q[q0+i] !== STREAM_BASE + 32'(s0 + i)) bad++;
      tests_run++;
      if (bad !== 0) begin
         tests_failed++;
         $display("FAIL skew%0d_data got %0d bad words want 0", aw_first, bad);
      end
      // 3 cycles per word with only the other channel still valid
      tests_run++;
      if (aw_first ? (aw_first_cyc - aw0 !== 384) : (w_first_cyc - w0 !== 384)) begin
         tests_failed++;
         $display("FAIL skew%0d_drop got aw_only_low=%0d w_only_low=%0d want 384 on the early side",
                  aw_first, aw_first_cyc - aw0, w_first_cyc - w0);
      end
   endtask

   task automatic test_slverr();
      int nwr, nd, kf, kd, q0, s0, exp_n;
      bit tmo;
`ifdef SD_WR_ABORT_ON_ERR_EN
      exp_n = 11;
`else
      exp_n = 128;
`endif
      err_at = addr_q.size() + 10;
      run_cmd(32'd3, 16'd1, 1000, nwr, nd, kf, kd, q0, s0, tmo);
      err_at = -1;
      tests_run++;
      if (tmo !== 1'b0 || nwr !== exp_n || stream_idx - s0 !== exp_n) begin
         tests_failed++;
         $display("FAIL slverr_count got writes=%0d consumed=%0d timeout=%0d want %0d",
                  nwr, stream_idx - s0, tmo, exp_n);
      end
      tests_run++;
      if (err !== 1'b1 || nd !== 1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL slverr_status got err=%b done=%0d ready=%b busy=%b want 1/1/1/0",
                  err, nd, cmd_ready, busy);
      end
   endtask

   task automatic test_zero_count();
      int q0;
      q0 = addr_q.size();
      cmd_sector = 32'd7;
      cmd_count  = 16'd0;
      cmd_valid  = 1'b1;
      @(negedge aclk);
      cmd_valid = 1'b0;
      tests_run++;
      if (done !== 1'b1 || cmd_ready !== 1'b0 || err !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_done got done=%b ready=%b err=%b want 1/0/0", done, cmd_ready, err);
      end
      @(negedge aclk);
      tests_run++;
      if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_idle got done=%b ready=%b busy=%b want 0/1/0", done, cmd_ready, busy);
      end
      repeat (3) @(negedge aclk);
      tests_run++;
      if (addr_q.size() - q0 !== 0 || m_axil_awvalid !== 1'b0 || s_tready !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL zero_quiet got writes=%0d awvalid=%b tready=%b done=%b want 0/0/0/0",
                  addr_q.size() - q0, m_axil_awvalid, s_tready, done);
      end
   endtask

   task automatic test_reset_midflight();
      int nwr, nd, kf, kd, q0, s0, bad;
      bit tmo, seen;
      aw_delay = 5;
      w_delay  = 5;
      cmd_sector = 32'd9;
      cmd_count  = 16'd1;
      cmd_valid  = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge aclk);
         cmd_valid = 1'b0;
         seen = m_axil_awvalid;
      end
      tests_run++;
      if (seen !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_reach_write got awvalid=%b want 1", seen);
      end
      aresetn = 1'b0;
      @(negedge aclk);
      aresetn = 1'b1;
      aw_delay = 0;
      w_delay  = 0;
      tests_run++;
      if ({m_axil_awvalid, m_axil_wvalid, m_axil_bready, s_tready, cmd_ready, busy} !== 6'b000010) begin
         tests_failed++;
         $display("FAIL rst_mid got aw/w/b/s/ready/busy=%b want 000010",
                  {m_axil_awvalid, m_axil_wvalid, m_axil_bready, s_tready, cmd_ready, busy});
      end
      run_cmd(32'd2, 16'd1, 1000, nwr, nd, kf, kd, q0, s0, tmo);
      bad = 0;
      for (int i = 0; i < nwr; i++)
         if (addr_q[q0+i] !== 32'h400 + 32'(i*4) || data_q[q0+i] !== STREAM_BASE + 32'(s0 + i)) bad++;
      tests_run++;
      if (tmo !== 1'b0 || nwr !== 128 || bad !== 0 || nd !== 1) begin
         tests_failed++;
         $display("FAIL rst_recover got writes=%0d bad=%0d done=%0d timeout=%0d want 128/0/1/0",
                  nwr, bad, nd, tmo);
      end
   endtask

   task automatic test_wrap();
      int nwr, nd, kf, kd, q0, s0;
      bit tmo;
      // Sector 0x7FFFFF starts at 0xFFFFFE00; the next sector wraps to address 0.
      run_cmd(32'h007F_FFFF, 16'd2, 2000, nwr, nd, kf, kd, q0, s0, tmo);
      tests_run++;
      if (tmo !== 1'b0 || nwr !== 256 || addr_q[q0] !== 32'hFFFFFE00 ||
          addr_q[q0+127] !== 32'hFFFFFFFC || addr_q[q0+128] !== 32'h0) begin
         tests_failed++;
         $display("FAIL wrap got writes=%0d first=%h w127=%h w128=%h want 256 fffffe00 fffffffc 0",
                  nwr, addr_q[q0], addr_q[q0+127], addr_q[q0+128]);
      end
   endtask

   initial begin
      aresetn    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_sector = '0;
      cmd_count  = '0;
      m_axil_bvalid = 1'b0;
      m_axil_bresp  = 2'b00;
      repeat (3) @(negedge aclk);
      aresetn = 1'b1;
      test_reset();
      test_single_sector();
      test_two_sectors();
      test_skew(1'b1);
      test_skew(1'b0);
      test_slverr();
      test_zero_count();
      test_reset_midflight();
      test_wrap();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
